// File: rtl/uart_tx_frame_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_frame_arbiter
//  Purpose  : Round-robin share of one UART transmitter; each grant is sent
//             as a SYNC/ID/DATA/CHK frame, with a stall watchdog.
//  Revision : 1.0
// ============================================================================
module uart_tx_frame_arbiter #(
    parameter int          NUM_REQ      = 4,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int          TIMEOUT_CLKS = 4096
) (
    input  logic                   i_Clock,
    input  logic                   i_Rst_n,
    input  logic [NUM_REQ-1:0]     i_Req,
    input  logic [8*NUM_REQ-1:0]   i_Byte,
    output logic [NUM_REQ-1:0]     o_Ack,
    output logic                   o_TX_DV,
    output logic [7:0]             o_TX_Byte,
    input  logic                   i_TX_Active,
    input  logic                   i_TX_Done,
    output logic                   o_Busy,
    output logic                   o_Frame_Done,
    output logic                   o_Err
);

    localparam int                  c_WDOG_W   = $clog2(TIMEOUT_CLKS) + 1;
    localparam logic [c_WDOG_W-1:0] c_WDOG_MAX = c_WDOG_W'(TIMEOUT_CLKS - 1);
    localparam logic [3:0]          c_NUM_REQ4 = 4'(NUM_REQ);
    localparam logic [NUM_REQ-1:0]  c_ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [2:0] {
        c_SYNC_WAIT = 3'd0,
        c_IDLE      = 3'd1,
        c_LOAD      = 3'd2,
        c_WAIT_DONE = 3'd3,
        c_WAIT_CLR  = 3'd4
    } state_t;

    state_t                r_State;
    logic [2:0]            r_Ptr;
    logic [1:0]            r_Idx;
    logic [7:0]            r_Id;
    logic [7:0]            r_Data;
    logic [c_WDOG_W-1:0]   r_Wdog;
    logic [NUM_REQ-1:0]    r_Ack;
    logic                  r_TX_DV;
    logic [7:0]            r_TX_Byte;
    logic                  r_Busy;
    logic                  r_Frame_Done;
    logic                  r_Err;

    logic                  w_Tx_Idle;
    logic [NUM_REQ-1:0]    w_Rot;
    logic                  w_Any_Req;
    logic [3:0]            w_Sum;
    logic [2:0]            w_Gnt;
    logic [3:0]            w_Gnt_P1;
    logic                  w_Wdog_Hit;

    assign w_Tx_Idle  = !i_TX_Active && !i_TX_Done;
    assign w_Wdog_Hit = (r_Wdog == c_WDOG_MAX);

    // Rotate requests so bit 0 is the RR pointer; lowest set bit wins.
    always_comb begin
        w_Rot     = NUM_REQ'({i_Req, i_Req} >> r_Ptr);
        w_Any_Req = 1'b0;
        w_Sum     = 4'd0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (w_Rot[j]) begin
                w_Any_Req = 1'b1;
                w_Sum     = {1'b0, r_Ptr} + 4'(j);
            end
        end
        w_Gnt    = (w_Sum >= c_NUM_REQ4) ? 3'(w_Sum - c_NUM_REQ4) : w_Sum[2:0];
        w_Gnt_P1 = {1'b0, w_Gnt} + 4'd1;
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_State      <= c_SYNC_WAIT;
            r_Ptr        <= 3'd0;
            r_Idx        <= 2'd0;
            r_Id         <= 8'h00;
            r_Data       <= 8'h00;
            r_Wdog       <= '0;
            r_Ack        <= '0;
            r_TX_DV      <= 1'b0;
            r_TX_Byte    <= 8'h00;
            r_Busy       <= 1'b0;
            r_Frame_Done <= 1'b0;
            r_Err        <= 1'b0;
        end else begin
            r_Ack        <= '0;
            r_TX_DV      <= 1'b0;
            r_Frame_Done <= 1'b0;
            r_Err        <= 1'b0;
            case (r_State)
                c_SYNC_WAIT: begin
                    if (w_Tx_Idle) begin
                        r_State <= c_IDLE;
                    end
                end
                c_IDLE: begin
                    if (w_Any_Req) begin
                        r_Ack   <= c_ONE_HOT0 << w_Gnt;
                        r_Data  <= i_Byte[8*w_Gnt +: 8];
                        r_Id    <= {5'b0, w_Gnt};
                        r_Idx   <= 2'd0;
                        r_Busy  <= 1'b1;
                        r_Ptr   <= (w_Gnt_P1 == c_NUM_REQ4) ? 3'd0 : w_Gnt_P1[2:0];
                        r_State <= c_LOAD;
                    end
                end
                c_LOAD: begin
                    case (r_Idx)
                        2'd0:    r_TX_Byte <= SYNC_BYTE;
                        2'd1:    r_TX_Byte <= r_Id;
                        2'd2:    r_TX_Byte <= r_Data;
                        default: r_TX_Byte <= SYNC_BYTE ^ r_Id ^ r_Data;
                    endcase
                    r_TX_DV <= 1'b1;
                    r_Wdog  <= '0;
                    r_State <= c_WAIT_DONE;
                end
                c_WAIT_DONE: begin
                    r_Wdog <= r_Wdog + 1'b1;
                    if (w_Wdog_Hit) begin
                        r_Err   <= 1'b1;
                        r_Busy  <= 1'b0;
                        r_State <= c_SYNC_WAIT;
                    end else if (i_TX_Done) begin
                        r_State <= c_WAIT_CLR;
                    end
                end
                c_WAIT_CLR: begin
                    r_Wdog <= r_Wdog + 1'b1;
                    if (w_Wdog_Hit) begin
                        r_Err   <= 1'b1;
                        r_Busy  <= 1'b0;
                        r_State <= c_SYNC_WAIT;
                    end else if (w_Tx_Idle) begin
                        if (r_Idx != 2'd3) begin
                            r_Idx   <= r_Idx + 2'd1;
                            r_State <= c_LOAD;
                        end else begin
                            r_Frame_Done <= 1'b1;
                            r_Busy       <= 1'b0;
                            r_State      <= c_IDLE;
                        end
                    end
                end
                default: r_State <= c_SYNC_WAIT;
            endcase
        end
    end

    assign o_Ack        = r_Ack;
    assign o_TX_DV      = r_TX_DV;
    assign o_TX_Byte    = r_TX_Byte;
    assign o_Busy       = r_Busy;
    assign o_Frame_Done = r_Frame_Done;
    assign o_Err        = r_Err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_frame_arbiter
//  Purpose  : Directed bench for uart_tx_frame_arbiter with a UART tx model.
//  Revision : 1.0
// ============================================================================
module tb_uart_tx_frame_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int TIMEOUT      = 64;
    localparam int CLKS_PER_BIT = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_bytes;
    logic [NUM_REQ-1:0]   ack;
    logic                 tx_dv;
    logic [7:0]           tx_byte;
    logic                 tx_active;
    logic                 tx_done;
    logic                 busy;
    logic                 frame_done;
    logic                 err;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] sent[$];
    int         grants[$];
    bit         stuck = 1'b0;

    always #5 clk = ~clk;

    uart_tx_frame_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .SYNC_BYTE    (8'hA5),
        .TIMEOUT_CLKS (TIMEOUT)
    ) dut (
        .i_Clock      (clk),
        .i_Rst_n      (rst_n),
        .i_Req        (req),
        .i_Byte       (req_bytes),
        .o_Ack        (ack),
        .o_TX_DV      (tx_dv),
        .o_TX_Byte    (tx_byte),
        .i_TX_Active  (tx_active),
        .i_TX_Done    (tx_done),
        .o_Busy       (busy),
        .o_Frame_Done (frame_done),
        .o_Err        (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits for the next frame-done pulse; busy must stay high until it.
    task automatic wait_frame(input string tag);
        int t;
        bit dropped;
        t = 0;
        dropped = 1'b0;
        do begin
            @(negedge clk);
            t++;
            if (frame_done !== 1'b1 && busy !== 1'b1) dropped = 1'b1;
        end while (frame_done !== 1'b1 && t < 1000);
        check({tag, "_done"}, frame_done, 1);
        check({tag, "_busy_held"}, dropped, 0);
    endtask

    // Transmitter: busy 10 bit times after a strobe, done held 2 cycles.
    initial begin : tx_model
        int busy_cnt;
        int done_cnt;
        bit dv_prev;
        bit hang;
        busy_cnt  = 0;
        done_cnt  = 0;
        dv_prev   = 1'b0;
        hang      = 1'b0;
        tx_active = 1'b0;
        tx_done   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) tx_done = 1'b0;
            end
            if (hang && !stuck) begin
                tx_active = 1'b0;
                hang      = 1'b0;
            end
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    if (stuck) hang = 1'b1;
                    else begin
                        tx_active = 1'b0;
                        tx_done   = 1'b1;
                        done_cnt  = 2;
                    end
                end
            end
            if (dv_prev) begin
                tx_active = 1'b1;
                busy_cnt  = 10 * CLKS_PER_BIT;
            end
            if (tx_dv) sent.push_back(tx_byte);
            dv_prev = tx_dv;
        end
    end

    initial begin : monitor
        bit prev_idle;
        prev_idle = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_dv) begin
                check("dv_prev_idle", prev_idle, 1);
                check("dv_tx_inactive", tx_active, 0);
            end
            if (ack != '0) begin
                check("ack_onehot", $onehot(ack), 1);
                for (int k = 0; k < NUM_REQ; k++) if (ack[k]) grants.push_back(k);
            end
            prev_idle = !tx_active && !tx_done;
        end
    end

    initial begin : guard
        #300000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int t;
        int base_g;
        int exp_g [5];
        logic [7:0] exp_b [20];
        exp_g = '{0, 1, 2, 3, 0};
        exp_b = '{8'hA5, 8'h00, 8'h10, 8'hB5,
                  8'hA5, 8'h01, 8'h20, 8'h84,
                  8'hA5, 8'h02, 8'h30, 8'h97,
                  8'hA5, 8'h03, 8'h40, 8'hE6,
                  8'hA5, 8'h00, 8'h10, 8'hB5};

        rst_n = 1'b0;
        req = '0;
        req_bytes = '0;
        repeat (3) @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_dv", tx_dv, 0);
        check("rst_byte", tx_byte, 0);
        check("rst_busy", busy, 0);
        check("rst_fd", frame_done, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single requester 2, payload 3C
        req_bytes[23:16] = 8'h3C;
        req = 4'b0100;
        @(negedge clk);
        check("t1_ack", ack, 4'b0100);
        check("t1_busy", busy, 1);
        req = '0;
        @(negedge clk);
        check("t1_ack_pulse", ack, 0);
        check("t1_sync_dv", tx_dv, 1);
        check("t1_sync_byte", tx_byte, 8'hA5);
        wait_frame("t1");
        @(negedge clk);
        check("t1_fd_pulse", frame_done, 0);
        check("t1_busy_clr", busy, 0);
        check("t1_nbytes", sent.size(), 4);
        check("t1_b0", sent[0], 8'hA5);
        check("t1_b1", sent[1], 8'h02);
        check("t1_b2", sent[2], 8'h3C);
        check("t1_b3", sent[3], 8'h9B);

        // Pointer is 3: requests 0 and 2 -> wrap to 0, then 2
        req_bytes[7:0]   = 8'h11;
        req_bytes[23:16] = 8'h22;
        req = 4'b0101;
        base_g = grants.size();
        wait_frame("t3a");
        wait_frame("t3b");
        req = '0;
        check("t3_ngrants", grants.size() - base_g, 2);
        check("t3_g0", grants[base_g], 0);
        check("t3_g1", grants[base_g + 1], 2);
        check("t3_nbytes", sent.size(), 12);
        check("t3_chk0", sent[7], 8'hB4);
        check("t3_chk1", sent[11], 8'h85);

        // Transmitter never finishes -> watchdog abort
        @(negedge clk);
        stuck = 1'b1;
        req_bytes[15:8] = 8'h55;
        req = 4'b0010;
        @(negedge clk);
        check("t4_ack", ack, 4'b0010);
        req = '0;
        @(negedge clk);
        check("t4_dv", tx_dv, 1);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (err !== 1'b1 && t < 2 * TIMEOUT);
        check("t4_err_latency", t, TIMEOUT);
        check("t4_busy", busy, 0);
        @(negedge clk);
        check("t4_err_pulse", err, 0);
        req_bytes[31:24] = 8'h77;
        req = 4'b1000;
        base_g = grants.size();
        repeat (10) @(negedge clk);
        check("t4_no_grant_stalled", grants.size() - base_g, 0);
        check("t4_no_retry", sent.size(), 13);
        stuck = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (ack === '0 && t < 20);
        check("t4_recover_ack", ack, 4'b1000);
        req = '0;

        // Reset during the DATA byte while the transmitter is busy
        t = 0;
        while (sent.size() < 16 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("t5_data_strobe", sent.size(), 16);
        check("t5_id", sent[14], 8'h03);
        check("t5_data", sent[15], 8'h77);
        repeat (4) @(negedge clk);
        check("t5_tx_active", tx_active, 1);
        rst_n = 1'b0;
        #1;
        check("t5_async_busy", busy, 0);
        @(negedge clk);
        check("t5_rst_dv", tx_dv, 0);
        check("t5_rst_byte", tx_byte, 0);
        check("t5_rst_busy", busy, 0);
        rst_n = 1'b1;
        t = 0;
        while ((tx_active || tx_done) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("t5_no_dv_while_active", sent.size(), 16);
        repeat (3) @(negedge clk);

        // All requesters held: rotation from a reset pointer
        req_bytes = {8'h40, 8'h30, 8'h20, 8'h10};
        req = 4'b1111;
        base_g = grants.size();
        for (int f = 0; f < 5; f++) wait_frame("t2");
        req = '0;
        check("t2_ngrants", grants.size() - base_g, 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("t2_grant%0d", i), grants[base_g + i], exp_g[i]);
        check("t2_nbytes", sent.size(), 36);
        for (int i = 0; i < 20; i++)
            check($sformatf("t2_byte%0d", i), sent[16 + i], exp_b[i]);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_frame_arbiter.md
Name: uart_tx_frame_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ byte requesters using round-robin arbitration.
- Wraps each granted byte in a fixed 4-byte frame: SYNC, ID, DATA, CHK.
- Sits between requester logic and the UART transmitter. It drives the transmitter's data-valid strobe and byte, and sequences on the transmitter's active/done outputs.
- Includes a watchdog that aborts a frame if the transmitter stalls.

Parameters:
- NUM_REQ, 4, number of requesters (2..8); ID byte carries the requester index.
- SYNC_BYTE, 8'hA5, first byte of every frame.
- TIMEOUT_CLKS, 4096, max clocks from strobe to byte-done before abort; must exceed 10*CLKS_PER_BIT+4.

Ports:
- i_Clock  in  1  single clock.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_Req  in  NUM_REQ  per-requester request level; held until acked.
- i_Byte  in  8*NUM_REQ  payload bytes; requester k occupies bits [8k+7:8k]; stable while i_Req[k]=1.
- o_Ack  out  NUM_REQ  one-cycle pulse, one-hot, when requester's byte is captured.
- o_TX_DV  out  1  one-cycle strobe to transmitter.
- o_TX_Byte  out  8  byte to transmitter; valid when o_TX_DV=1 and held until the next strobe.
- i_TX_Active  in  1  transmitter busy.
- i_TX_Done  in  1  transmitter done (may stay high up to 2 cycles).
- o_Busy  out  1  frame in progress (SYNC_WAIT excluded).
- o_Frame_Done  out  1  one-cycle pulse after CHK byte completes.
- o_Err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (async assert, sync release):
  - o_Ack=0, o_TX_DV=0, o_TX_Byte=0, o_Busy=0, o_Frame_Done=0, o_Err=0.
  - RR pointer=0, byte index=0, watchdog=0, state=SYNC_WAIT.
- Transmitter-idle condition: i_TX_Active=0 and i_TX_Done=0.
- States:
  - SYNC_WAIT: stay until the transmitter is idle, then go to IDLE. This covers reset released while the transmitter is mid-byte.
  - IDLE: if any i_Req bit is set, grant the first set bit searching upward from the RR pointer with wrap.
    - In the same registered cycle: o_Ack[g]=1, latch DATA=i_Byte[g], ID={5'b0,g[2:0]}, byte index=0, o_Busy=1, then go to LOAD.
    - RR pointer becomes (g+1) mod NUM_REQ.
  - LOAD: select the byte by index (0 SYNC, 1 ID, 2 DATA, 3 CHK=SYNC^ID^DATA), register it on o_TX_Byte, pulse o_TX_DV for exactly one cycle, clear watchdog, go to WAIT_DONE.
  - WAIT_DONE: increment watchdog each cycle; on i_TX_Done=1 go to WAIT_CLR.
  - WAIT_CLR: increment watchdog; once the transmitter is idle:
    - if index<3: index+1, go to LOAD;
    - else: pulse o_Frame_Done, o_Busy=0, go to IDLE.
  - Watchdog: when it reaches TIMEOUT_CLKS-1 in WAIT_DONE or WAIT_CLR, pulse o_Err, o_Busy=0, go to SYNC_WAIT. The frame is abandoned; no retry and no re-ack.
- Timing:
  - Strobe spacing: o_TX_DV is never asserted unless the transmitter was idle the previous cycle.
  - The transmitter cleanup window therefore never swallows a strobe.
  - Latency from i_Req rising in IDLE to o_Ack is 1 cycle; o_TX_DV for SYNC follows 1 cycle after o_Ack.
- Arbitration details:
  - A requester dropping i_Req before ack is simply not granted.
  - Requests arriving mid-frame wait; no preemption.
  - All requesters asserted continuously: grants rotate 0,1,2,3,0,...
  - Single requester asserted continuously: granted every frame.
- Reset asserted mid-frame: all outputs clear immediately, the frame is lost, then SYNC_WAIT.
- CHK is an 8-bit XOR with no carry. ID upper bits are zero.

Test Plan:
- Bench transmitter CLKS_PER_BIT=4, NUM_REQ=4. Req[2]=1, Byte[2]=8'h3C → Ack[2] pulse 1 cycle after req; serial line carries A5,02,3C,9B; o_Frame_Done one pulse; o_Busy high from ack until frame done.
- Req=4'b1111, bytes 10,20,30,40 held and re-asserted after each ack → frame IDs 0,1,2,3,0 in order; exactly one o_Ack bit per frame.
- RR pointer at 3 after granting 2; then Req=4'b0101 → grant 0 (wrap), next grant 2.
- Transmitter model never asserts done → o_Err pulse exactly TIMEOUT_CLKS cycles after SYNC strobe; o_Busy=0; returns to IDLE once the model goes idle.
- Reset pulsed during DATA byte while the transmitter is still active → outputs 0 during reset; no o_TX_DV until i_TX_Active and i_TX_Done both low; next request produces a complete frame.
- Check every o_TX_DV against a monitor: it is preceded by a cycle with i_TX_Active=0 and i_TX_Done=0; no strobe while the transmitter is active; exactly 4 strobes per frame.
